// File: rtl/color_sched_pkg.sv
// Shared types for the triangle colour-fill scheduler: geometry, colour, queued job and FSM states.
package color_sched_pkg;

  localparam int unsigned COLOR_SCHED_DEPTH = 4;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  typedef struct packed {
    Triangle3D ver;
    Color      rgb;
    shortint   height;
  } ColorJob;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_RUN,
    ST_FRAME
  } sched_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/color_sched_if.sv
// Job intake handshake from triangle setup plus the launch/done handshake to colorloop.
interface color_sched_if;
  import color_sched_pkg::*;

  logic        tri_valid;
  logic        tri_ready;
  Triangle3D   tri_in;
  Color        tri_color;
  logic [15:0] tri_height;

  logic        cl_done;
  logic        cl_color_en;
  Triangle3D   cl_ver;
  Color        cl_rgb;
  logic [15:0] cl_height;

  // master: the scheduler; slave: setup stage and colorloop around it
  modport master (
    input  tri_valid, tri_in, tri_color, tri_height, cl_done,
    output tri_ready, cl_color_en, cl_ver, cl_rgb, cl_height
  );

  modport slave (
    output tri_valid, tri_in, tri_color, tri_height, cl_done,
    input  tri_ready, cl_color_en, cl_ver, cl_rgb, cl_height
  );

endinterface

// File: rtl/color_sched_job_fifo.sv
// Circular-buffer FIFO of ColorJob with occupancy count; head is readable combinationally.
module job_fifo
  import color_sched_pkg::*;
#(
  parameter int unsigned DEPTH = COLOR_SCHED_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  ColorJob din,
  output ColorJob head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  ColorJob          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/color_sched.sv
// Buffers rasterization jobs and launches one colorloop pass at a time, with watchdog and frame accounting.
module color_sched
  import color_sched_pkg::*;
#(
  parameter int unsigned DEPTH    = COLOR_SCHED_DEPTH,
  parameter int unsigned MAX_WAIT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  color_sched_if.master     bus,
  input  logic              flush,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout,
  output logic [15:0]       tri_count
);

  localparam int unsigned WD_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  sched_state_e    state_q, state_d;
  ColorJob         job_q, job_d;
  logic            cl_color_en_q, cl_color_en_d;
  logic            frame_done_q, frame_done_d;
  logic            timeout_q, timeout_d;
  logic            flush_pend_q, flush_pend_d;
  logic [15:0]     tri_count_q, tri_count_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  ColorJob fifo_din, fifo_head;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

  always_comb begin
    fifo_din.ver    = bus.tri_in;
    fifo_din.rgb    = bus.tri_color;
    fifo_din.height = bus.tri_height;
  end

  assign fifo_push = bus.tri_valid && !fifo_full;

  job_fifo #(.DEPTH(DEPTH)) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    timeout_d    = timeout_q;
    flush_pend_d = flush_pend_q;
    tri_count_d  = tri_count_q;
    wdog_d       = wdog_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)       state_d = ST_LOAD;
        else if (flush_pend_q) state_d = ST_FRAME;
      end
      ST_LOAD: begin
        job_d    = fifo_head;
        fifo_pop = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A completed pass with work queued skips IDLE so the next launch follows done by two cycles.
        if (bus.cl_done) begin
          tri_count_d = sat_inc16(tri_count_q);
          state_d     = fifo_empty ? ST_IDLE : ST_LOAD;
        end else if (wdog_q == WD_W'(MAX_WAIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_FRAME: begin
        tri_count_d  = '0;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush && state_q != ST_FRAME) flush_pend_d = 1'b1;

    cl_color_en_d = (state_d == ST_ISSUE);
    frame_done_d  = (state_d == ST_FRAME);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      job_q         <= '0;
      cl_color_en_q <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      flush_pend_q  <= 1'b0;
      tri_count_q   <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      job_q         <= job_d;
      cl_color_en_q <= cl_color_en_d;
      frame_done_q  <= frame_done_d;
      timeout_q     <= timeout_d;
      flush_pend_q  <= flush_pend_d;
      tri_count_q   <= tri_count_d;
      wdog_q        <= wdog_d;
    end
  end

  assign bus.tri_ready   = !fifo_full;
  assign bus.cl_color_en = cl_color_en_q;
  assign bus.cl_ver      = job_q.ver;
  assign bus.cl_rgb      = job_q.rgb;
  assign bus.cl_height   = job_q.height;

  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign frame_done = frame_done_q;
  assign timeout    = timeout_q;
  assign tri_count  = tri_count_q;

endmodule

// File: tb/tb_color_sched.sv
// Directed bench for color_sched: single job, back-pressure, flush, watchdog, stray events, reset mid-pass.
module tb_color_sched;
  import color_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy, frame_done, timeout;
  logic [15:0] tri_count;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  color_sched_if bus ();

  color_sched #(.DEPTH(4), .MAX_WAIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout    (timeout),
    .tri_count  (tri_count)
  );

  always #5 clk = ~clk;

  localparam Color RED  = 24'hFF0000;
  localparam Color BLUE = 24'h0000FF;

  function automatic Triangle3D make_tri(input logic [15:0] h);
    Triangle3D t;
    t.v0 = '{x: h, y: h + 16'd1, z: h + 16'd2};
    t.v1 = '{x: h + 16'd3, y: h + 16'd4, z: h + 16'd5};
    t.v2 = '{x: h + 16'd6, y: h + 16'd7, z: h + 16'd8};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic drive_job(input logic [15:0] h, input Color c);
    bus.tri_valid  = 1'b1;
    bus.tri_height = h;
    bus.tri_color  = c;
    bus.tri_in     = make_tri(h);
  endtask

  // Called in an ISSUE cycle: completes that pass one cycle later and expects the next launch two cycles after done.
  task automatic complete_expect(input string tag, input logic [15:0] next_h);
    tick();
    bus.cl_done = 1'b1;
    tick();
    bus.cl_done = 1'b0;
    check({tag, "_gap_en"}, bus.cl_color_en, 1'b0);
    tick();
    check({tag, "_launch_en"}, bus.cl_color_en, 1'b1);
    check({tag, "_launch_h"}, bus.cl_height, next_h);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, observed %0t expected < 100000", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.tri_valid  = 1'b0;
    bus.tri_in     = '0;
    bus.tri_color  = '0;
    bus.tri_height = '0;
    bus.cl_done    = 1'b0;
    tick();
    tick();
    check("rst_tri_ready", bus.tri_ready, 1'b1);
    check("rst_cl_en", bus.cl_color_en, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cl_height", bus.cl_height, 16'd0);
    check("rst_tri_count", tri_count, 16'd0);
    rst = 1'b0;
    tick();

    // Single job: launch two cycles after the push, operands held, counted on done.
    drive_job(16'd5, RED);
    tick();
    bus.tri_valid = 1'b0;
    check("t1_busy_queued", busy, 1'b1);
    check("t1_en_idle", bus.cl_color_en, 1'b0);
    tick();
    check("t1_en_load", bus.cl_color_en, 1'b0);
    tick();
    check("t1_en_issue", bus.cl_color_en, 1'b1);
    check("t1_height", bus.cl_height, 16'd5);
    check("t1_rgb", bus.cl_rgb, RED);
    check("t1_ver", bus.cl_ver, make_tri(16'd5));
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t1_hold_height", bus.cl_height, 16'd5);
      check("t1_hold_en", bus.cl_color_en, 1'b0);
      if (i == 10) bus.cl_done = 1'b1;
    end
    tick();
    bus.cl_done = 1'b0;
    check("t1_count", tri_count, 16'd1);
    check("t1_busy_done", busy, 1'b0);

    // Back-pressure: five back-to-back pushes, done withheld.
    for (int j = 0; j < 5; j++) begin
      check("t2_ready_before_push", bus.tri_ready, 1'b1);
      drive_job(16'(10 + j), BLUE);
      tick();
      check("t2_en_during_pushes", bus.cl_color_en, (j == 2) ? 1'b1 : 1'b0);
    end
    bus.tri_valid = 1'b0;
    check("t2_ready_full", bus.tri_ready, 1'b0);
    check("t2_first_height", bus.cl_height, 16'd10);
    complete_expect("t2_j11", 16'd11);
    check("t2_ready_after_pop", bus.tri_ready, 1'b1);
    complete_expect("t2_j12", 16'd12);
    complete_expect("t2_j13", 16'd13);
    complete_expect("t2_j14", 16'd14);
    tick();
    bus.cl_done = 1'b1;
    tick();
    bus.cl_done = 1'b0;
    check("t2_count", tri_count, 16'd6);
    check("t2_busy_drained", busy, 1'b0);

    // Stray done while idle is ignored.
    bus.cl_done = 1'b1;
    tick();
    bus.cl_done = 1'b0;
    tick();
    check("stray_count", tri_count, 16'd6);
    check("stray_en", bus.cl_color_en, 1'b0);

    // Flush with nothing queued: frame_done two cycles after flush.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fe_frame_early", frame_done, 1'b0);
    tick();
    check("fe_frame_pulse", frame_done, 1'b1);
    check("fe_count_in_pulse", tri_count, 16'd6);
    tick();
    check("fe_frame_end", frame_done, 1'b0);
    check("fe_count_cleared", tri_count, 16'd0);

    // Flush after three queued jobs: frame_done two cycles after the third done.
    for (int j = 0; j < 3; j++) begin
      drive_job(16'(20 + j), RED);
      tick();
    end
    bus.tri_valid = 1'b0;
    check("t3_first_en", bus.cl_color_en, 1'b1);
    check("t3_first_height", bus.cl_height, 16'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    complete_expect("t3_j21", 16'd21);
    complete_expect("t3_j22", 16'd22);
    tick();
    bus.cl_done = 1'b1;
    tick();
    bus.cl_done = 1'b0;
    check("t3_frame_early", frame_done, 1'b0);
    check("t3_count_pre", tri_count, 16'd3);
    tick();
    check("t3_frame_pulse", frame_done, 1'b1);
    check("t3_count_in_pulse", tri_count, 16'd3);
    tick();
    check("t3_frame_end", frame_done, 1'b0);
    check("t3_count_cleared", tri_count, 16'd0);

    // Push and flush in the same cycle: that job belongs to the frame.
    drive_job(16'd30, BLUE);
    flush = 1'b1;
    tick();
    bus.tri_valid = 1'b0;
    flush = 1'b0;
    check("pf_frame_early", frame_done, 1'b0);
    tick();
    tick();
    check("pf_en", bus.cl_color_en, 1'b1);
    check("pf_height", bus.cl_height, 16'd30);
    check("pf_frame_not_yet", frame_done, 1'b0);
    tick();
    bus.cl_done = 1'b1;
    tick();
    bus.cl_done = 1'b0;
    check("pf_count", tri_count, 16'd1);
    check("pf_frame_wait", frame_done, 1'b0);
    tick();
    check("pf_frame_pulse", frame_done, 1'b1);
    tick();
    check("pf_count_cleared", tri_count, 16'd0);

    // Watchdog: decision in the 16th RUN cycle, job dropped, next job launches.
    drive_job(16'd40, RED);
    tick();
    drive_job(16'd41, BLUE);
    tick();
    bus.tri_valid = 1'b0;
    tick();
    check("wd_en_first", bus.cl_color_en, 1'b1);
    check("wd_height_first", bus.cl_height, 16'd40);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("wd_timeout_low", timeout, 1'b0);
    end
    tick();
    check("wd_timeout_set", timeout, 1'b1);
    check("wd_not_counted", tri_count, 16'd0);
    check("wd_en_idle", bus.cl_color_en, 1'b0);
    tick();
    check("wd_en_load", bus.cl_color_en, 1'b0);
    tick();
    check("wd_en_next", bus.cl_color_en, 1'b1);
    check("wd_height_next", bus.cl_height, 16'd41);
    tick();
    bus.cl_done = 1'b1;
    tick();
    bus.cl_done = 1'b0;
    check("wd_next_counted", tri_count, 16'd1);
    check("wd_timeout_sticky", timeout, 1'b1);

    // Reset during RUN with two jobs still queued.
    for (int j = 0; j < 3; j++) begin
      drive_job(16'(50 + j), RED);
      tick();
    end
    bus.tri_valid = 1'b0;
    check("rr_en_first", bus.cl_color_en, 1'b1);
    tick();
    check("rr_busy_run", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rr_height", bus.cl_height, 16'd0);
    check("rr_timeout", timeout, 1'b0);
    check("rr_count", tri_count, 16'd0);
    check("rr_busy", busy, 1'b0);
    check("rr_ready", bus.tri_ready, 1'b1);
    check("rr_en", bus.cl_color_en, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_no_launch", bus.cl_color_en, 1'b0);
      check("rr_fifo_empty", busy, 1'b0);
    end
    drive_job(16'd60, BLUE);
    tick();
    bus.tri_valid = 1'b0;
    tick();
    check("rr_new_load", bus.cl_color_en, 1'b0);
    tick();
    check("rr_new_en", bus.cl_color_en, 1'b1);
    check("rr_new_height", bus.cl_height, 16'd60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
